// File: rtl/pll_freq_monitor.sv
// PLL frequency monitor: counts synchronized meas_in rising edges over back-to-back
// gate windows of the reference clock and qualifies the rate over consecutive windows.
module pll_freq_monitor #(
  parameter int GATE_CYCLES  = 27000,
  parameter int CNT_W        = 16,
  parameter int EXP_MIN      = 0,
  parameter int EXP_MAX      = 65535,
  parameter int SYNC_STAGES  = 2,
  parameter int GOOD_WINDOWS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             meas_in,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             overflow,
  output logic             freq_ok
);

  localparam int GATE_W = $clog2(GATE_CYCLES);
  localparam int FL_W   = $clog2(SYNC_STAGES + 1);
  localparam int GOOD_W = $clog2(GOOD_WINDOWS + 1);

  localparam logic [GATE_W-1:0] GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
  localparam logic [FL_W-1:0]   FLUSH_LAST = FL_W'(SYNC_STAGES);
  localparam logic [GOOD_W-1:0] GOOD_MAX   = GOOD_W'(GOOD_WINDOWS);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  typedef enum logic [1:0] {IDLE, FLUSH, MEASURE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;
  logic                   meas_edge;
  logic [GATE_W-1:0]      gate_cnt;
  logic [FL_W-1:0]        flush_cnt;
  logic [CNT_W-1:0]       edge_cnt;
  logic                   ovf_int;
  logic [GOOD_W-1:0]      good_cnt;

  logic                   sync_out;
  logic [CNT_W-1:0]       fin_cnt;
  logic                   fin_ovf;
  logic                   in_range;
  logic [GOOD_W-1:0]      good_nxt;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Window totals including this cycle's edge, so the closing cycle's edge is kept.
  always_comb begin
    fin_cnt = edge_cnt;
    fin_ovf = ovf_int;
    if (meas_edge) begin
      if (edge_cnt == CNT_MAX) fin_ovf = 1'b1;
      else                     fin_cnt = edge_cnt + 1'b1;
    end
  end

  assign in_range = !fin_ovf && (int'(fin_cnt) >= EXP_MIN) && (int'(fin_cnt) <= EXP_MAX);

  always_comb begin
    good_nxt = '0;
    if (in_range) good_nxt = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sync_q      <= '0;
      prev        <= 1'b0;
      meas_edge   <= 1'b0;
      gate_cnt    <= '0;
      flush_cnt   <= '0;
      edge_cnt    <= '0;
      ovf_int     <= 1'b0;
      good_cnt    <= '0;
      count       <= '0;
      count_valid <= 1'b0;
      overflow    <= 1'b0;
      freq_ok     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], meas_in};
      prev        <= sync_out;
      meas_edge   <= sync_out & ~prev;
      count_valid <= 1'b0;
      if (!enable) begin
        // Partial window is dropped; count/overflow keep the last reported result.
        state     <= IDLE;
        gate_cnt  <= '0;
        flush_cnt <= '0;
        edge_cnt  <= '0;
        ovf_int   <= 1'b0;
        good_cnt  <= '0;
        freq_ok   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            gate_cnt  <= '0;
            flush_cnt <= '0;
            edge_cnt  <= '0;
            ovf_int   <= 1'b0;
            state     <= FLUSH;
          end
          FLUSH: begin
            if (flush_cnt == FLUSH_LAST) begin
              state    <= MEASURE;
              gate_cnt <= '0;
              edge_cnt <= '0;
              ovf_int  <= 1'b0;
            end else begin
              flush_cnt <= flush_cnt + 1'b1;
            end
          end
          MEASURE: begin
            if (gate_cnt == GATE_LAST) begin
              count       <= fin_cnt;
              overflow    <= fin_ovf;
              count_valid <= 1'b1;
              good_cnt    <= good_nxt;
              freq_ok     <= (good_nxt == GOOD_MAX);
              gate_cnt    <= '0;
              edge_cnt    <= '0;
              ovf_int     <= 1'b0;
            end else begin
              gate_cnt <= gate_cnt + 1'b1;
              edge_cnt <= fin_cnt;
              ovf_int  <= fin_ovf;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_freq_monitor.sv
// Directed bench for pll_freq_monitor: main instance (8-bit count, 9..11 range) and a
// 4-bit instance (9..15 range, one good window) for saturation and overflow gating.
module tb_pll_freq_monitor;

  logic       clk = 1'b0;
  logic       rst_n, enable, en4;
  logic       meas_in, meas4;
  logic [7:0] count;
  logic       cv, ovf, fok;
  logic [3:0] count4;
  logic       cv4, ovf4, fok4;

  int   per = 10, per4 = 4, ph = 0, ph4 = 0;
  bit   man_mode = 1'b0;
  logic meas_man = 1'b0;

  int n_run = 0, n_fail = 0;

  always #5 clk = ~clk;

  // Square-wave sources advance on the falling edge, away from DUT sampling.
  always @(negedge clk) begin
    ph  <= (ph  >= per  - 1) ? 0 : ph  + 1;
    ph4 <= (ph4 >= per4 - 1) ? 0 : ph4 + 1;
  end

  assign meas_in = man_mode ? meas_man : (ph < per / 2);
  assign meas4   = (ph4 < per4 / 2);

  pll_freq_monitor #(
    .GATE_CYCLES(100), .CNT_W(8), .EXP_MIN(9), .EXP_MAX(11),
    .SYNC_STAGES(2), .GOOD_WINDOWS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .meas_in(meas_in),
    .count(count), .count_valid(cv), .overflow(ovf), .freq_ok(fok)
  );

  pll_freq_monitor #(
    .GATE_CYCLES(100), .CNT_W(4), .EXP_MIN(9), .EXP_MAX(15),
    .SYNC_STAGES(2), .GOOD_WINDOWS(1)
  ) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(en4), .meas_in(meas4),
    .count(count4), .count_valid(cv4), .overflow(ovf4), .freq_ok(fok4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Counts falling edges until a count_valid is seen (sel=1 watches dut4).
  task automatic wait_cv(input bit sel, input int lim, output int n);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(sel ? cv4 : cv) && k < lim);
    if (!(sel ? cv4 : cv)) chk("cv_timeout", sel ? cv4 : cv, 1);
    n = k;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k;
    rst_n  = 1'b0;
    enable = 1'b0;
    en4    = 1'b0;
    #1;
    chk("rst_cv", cv, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_fok", fok, 0);
    chk("rst_fok4", fok4, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Period 10: ten edges per window, freq_ok on the fourth report
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wait_cv(0, 200, n);
      chk(i == 1 ? "first_latency" : "window_period", n, i == 1 ? 104 : 100);
      chk("p10_count", count, 10);
      chk("p10_ovf", ovf, 0);
      chk("p10_fok", fok, i == 4);
    end

    // Period 8: first full window is out of range and drops freq_ok at once
    per = 8;
    wait_cv(0, 200, n);
    wait_cv(0, 200, n);
    chk("p8_count_12_13", (count == 8'd12) || (count == 8'd13), 1);
    chk("p8_fok_drop", fok, 0);
    per = 10;
    wait_cv(0, 200, n);
    for (int i = 2; i <= 5; i++) begin
      wait_cv(0, 200, n);
      chk("restore_count", count, 10);
      if (i <= 3) chk("restore_fok_low", fok, 0);
      if (i == 5) chk("restore_fok_high", fok, 1);
    end

    // Drop enable at gate_cnt=50, then re-enable
    repeat (50) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("drop_fok", fok, 0);
    chk("drop_count_hold", count, 10);
    k = (cv === 1'b1) ? 1 : 0;
    repeat (150) begin
      @(negedge clk);
      if (cv) k++;
    end
    chk("drop_no_cv", k, 0);
    enable = 1'b1;
    wait_cv(0, 200, n);
    chk("reenable_latency", n, 104);
    chk("reenable_count", count, 10);
    chk("reenable_fok", fok, 0);

    // meas_in held high: no edge in the first window
    enable = 1'b0;
    @(negedge clk);
    man_mode = 1'b1;
    meas_man = 1'b1;
    repeat (10) @(negedge clk);
    enable = 1'b1;
    wait_cv(0, 200, n);
    chk("held1_latency", n, 104);
    chk("held1_count", count, 0);

    // Edge landing on gate_cnt==99 belongs to the ending window
    enable   = 1'b0;
    meas_man = 1'b0;
    repeat (10) @(negedge clk);
    enable = 1'b1;
    repeat (100) @(negedge clk);
    meas_man = 1'b1;
    wait_cv(0, 50, n);
    chk("bnd_latency", n, 4);
    chk("bnd_count", count, 1);
    chk("bnd_ovf", ovf, 0);
    wait_cv(0, 200, n);
    chk("bnd_next_count", count, 0);

    // Reset mid-window with freq_ok high
    man_mode = 1'b0;
    enable   = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) wait_cv(0, 200, n);
    chk("pre_rst_fok", fok, 1);
    repeat (30) @(negedge clk);
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_cv", cv, 0);
    chk("async_rst_ovf", ovf, 0);
    chk("async_rst_fok", fok, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    repeat (500) begin
      @(negedge clk);
      if (cv) k++;
    end
    chk("post_rst_no_cv", k, 0);
    chk("post_rst_fok", fok, 0);

    // 4-bit counter, 25 edges per window: saturates and never qualifies
    en4 = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      wait_cv(1, 200, n);
      chk("sat_count", count4, 15);
      chk("sat_ovf", ovf4, 1);
      chk("sat_fok", fok4, 0);
    end
    per4 = 10;
    wait_cv(1, 200, n);
    wait_cv(1, 200, n);
    chk("c4_count", count4, 10);
    chk("c4_ovf", ovf4, 0);
    chk("c4_fok", fok4, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
